serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial subtraction sequencer for the multicycle CPU datapath.
- Computes `result = op_a - op_b` over WIDTH cycles by reusing one external 1-bit subtractor slice (a, b, c_in → diff, c_out), one bit per cycle, LSB first.
- Owns operand/result shift registers, the carry flop and the start/busy/done handshake.
- Lets the CPU FSM trade latency for area on SUB/compare instructions.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_a  input  WIDTH  minuend; captured on accepted start.
- op_b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  difference; held until next accepted start.
- no_borrow  output  1  final slice carry-out; 1 ⇔ op_a ≥ op_b unsigned.
- slice_a  output  1  current op_a bit to slice.
- slice_b  output  1  current op_b bit to slice (slice inverts internally).
- slice_cin  output  1  carry into slice.
- slice_diff  input  1  slice difference bit.
- slice_cout  input  1  slice carry-out.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high, on rst.
- Reset values: state=IDLE, busy=0, done=0, result=0, no_borrow=0, slice_a/slice_b/slice_cin=0, counter=0, carry=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - a_sh←op_a, b_sh←op_b, carry←1 (two's-complement +1), cnt←0, result←0.
  - Go to RUN.
- IDLE, start=0: stay.
- RUN, combinational slice drive: slice_a=a_sh[0], slice_b=b_sh[0], slice_cin=carry.
- RUN, each edge:
  - result←{slice_diff, result[WIDTH-1:1]}; carry←slice_cout.
  - a_sh, b_sh shift right with 0 fill; cnt←cnt+1.
  - When cnt==WIDTH-1: no_borrow←slice_cout, go to DONE.
- Outside RUN: slice_a, slice_b and slice_cin are 0.
- DONE: done=1 for exactly one cycle, busy=0; unconditional return to IDLE at the next edge.
- Latency: start accepted at E0 → RUN occupies cycles E0..E0+WIDTH. done is high in the cycle following edge E0+WIDTH, i.e. WIDTH+1 cycles after start is sampled.
- busy is high during cycles E0+1..E0+WIDTH.
- start in RUN or DONE: ignored, no queuing. A new start is accepted only from IDLE, earliest in the cycle after done.
- op_a/op_b changes after capture: no effect.
- result/no_borrow: stable from done until the next accepted start; cleared/overwritten on that start.
- rst in any state, including mid-RUN: immediate return to reset values. The partial result is discarded and done is not pulsed.
- Arithmetic: modulo 2^WIDTH. No sign extension; the signed interpretation is left to the consumer.

Optional Feature:
- Macro: SERIAL_SUB_FLAGS_EN.
- Defined:
  - Adds outputs zero (1) and ovf (1); both reset to 0 and update in the same cycle as no_borrow, held with result.
  - zero=1 iff the final result==0.
  - ovf = signed overflow = (op_a[MSB]≠op_b[MSB]) && (result[MSB]≠op_a[MSB]). Operand MSBs are latched at start.
- Undefined: the ports and their logic are absent.

Test Plan:
- WIDTH=8, op_a=0x35, op_b=0x12, start pulse → done exactly 9 cycles after start edge, result=0x23, no_borrow=1, busy high 8 cycles. Slice trace: slice_cin=1 on bit0.
- op_a=0x12, op_b=0x35 → result=0xDD, no_borrow=0; ovf=0 (flags build).
- op_a=0x80, op_b=0x80 → result=0x00, no_borrow=1, zero=1, ovf=0. op_a=0x80, op_b=0x01 → result=0x7F, ovf=1.
- Second start asserted in every RUN cycle plus DONE cycle → ignored: one done only, result unchanged. A start in the cycle after done → new operation accepted.
- rst=1 at the edge after bit 3 processed → next cycle busy=0, done=0, result=0, slice_* =0, state IDLE. No done pulse follows.
- Operands changed on every cycle during RUN → result still matches values captured at start (0x35−0x12=0x23).

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtraction sequencer for the multicycle CPU.
// Computes result = op_a - op_b over WIDTH cycles, LSB first, through one
// external 1-bit subtractor slice. The slice is expected to invert slice_b
// internally, so each step is a + ~b + cin, with the carry seeded to 1.
//
// Optional build macro: SERIAL_SUB_FLAGS_EN adds the zero and ovf flag outputs.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             request, sampled only in IDLE
//   op_a, op_b        minuend / subtrahend, captured on accepted start
//   busy              high while bits are being processed
//   done              one-cycle pulse, result valid
//   result            difference, held until the next accepted start
//   no_borrow         final slice carry-out (1 <=> op_a >= op_b unsigned)
//   slice_a/b/cin     operand bits and carry driven to the slice (0 outside RUN)
//   slice_diff/cout   slice difference bit and carry-out
//   zero, ovf         (flags build) result==0, signed overflow
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             no_borrow,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  input  logic             slice_diff,
  input  logic             slice_cout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             last_bit_c;
  logic [WIDTH-1:0] next_result_c;

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb;
  logic b_msb;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  assign last_bit_c    = (state == S_RUN) && (cnt == LAST_BIT);
  assign next_result_c = {slice_diff, result[WIDTH-1:1]};

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_RUN;
      S_RUN:   if (last_bit_c) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Slice drive: only meaningful while processing bits, forced low otherwise
  assign slice_a   = (state == S_RUN) & a_sh[0];
  assign slice_b   = (state == S_RUN) & b_sh[0];
  assign slice_cin = (state == S_RUN) & carry;

  // Datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      no_borrow <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero      <= 1'b0;
      ovf       <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
`endif
    end else begin
      busy <= (next_state == S_RUN);
      done <= (next_state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh      <= op_a;
            b_sh      <= op_b;
            carry     <= 1'b1;  // +1 of the two's-complement negate
            cnt       <= '0;
            result    <= '0;
            no_borrow <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
            zero      <= 1'b0;
            ovf       <= 1'b0;
            a_msb     <= op_a[WIDTH-1];
            b_msb     <= op_b[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          result <= next_result_c;
          carry  <= slice_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit_c) begin
            no_borrow <= slice_cout;
`ifdef SERIAL_SUB_FLAGS_EN
            zero      <= (next_result_c == '0);
            // slice_diff is the result MSB on the last step
            ovf       <= (a_msb != b_msb) && (slice_diff != a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: behavioural 1-bit slice model,
// expected results queued at start and compared when done pulses.
module tb_serial_sub_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             no_borrow;
  logic             slice_a;
  logic             slice_b;
  logic             slice_cin;
  logic             slice_diff;
  logic             slice_cout;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Expected {result, no_borrow, zero, ovf}
  logic [WIDTH+2:0] exp_q[$];

  always #5 clk = ~clk;

  // External subtractor slice: a + ~b + cin
  assign slice_diff = slice_a ^ ~slice_b ^ slice_cin;
  assign slice_cout = (slice_a & ~slice_b) | (slice_a & slice_cin) | (~slice_b & slice_cin);

  serial_sub_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .no_borrow  (no_borrow),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_diff (slice_diff),
    .slice_cout (slice_cout)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero       (zero),
    .ovf        (ovf)
`endif
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, result, no_borrow, slice_a, slice_b, slice_cin} !== '0) begin
      n_errors++;
      $display("FAIL reset: busy=%b done=%b result=%h nb=%b slice=%b%b%b required all 0",
               busy, done, result, no_borrow, slice_a, slice_b, slice_cin);
    end
`ifdef SERIAL_SUB_FLAGS_EN
    n_checks++;
    if ({zero, ovf} !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_flags: zero=%b ovf=%b required 00", zero, ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Runs one subtraction; called at a negedge, returns at the negedge after done.
  task automatic test_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit hold_start, input bit scramble);
    logic [WIDTH-1:0] d;
    logic [WIDTH+2:0] exp_v;
    logic [WIDTH+2:0] got_v;
    int cyc;
    int busy_cnt;
    int done_cnt;
    bit got;
    d = a - b;
    exp_q.push_back({d, (a >= b), (d == '0),
                     ((a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]))});
    op_a = a; op_b = b; start = 1'b1;
    cyc = 0; busy_cnt = 0; done_cnt = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!hold_start) start = 1'b0;
      if (scramble) begin
        op_a = WIDTH'($urandom);
        op_b = WIDTH'($urandom);
      end
      if (busy) busy_cnt++;
      if (cyc >= 1 && cyc <= int'(WIDTH)) begin
        n_checks++;
        if (slice_a !== a[cyc-1] || slice_b !== b[cyc-1]) begin
          n_errors++;
          $display("FAIL slice_bits[%0d]: a=%b b=%b required a=%b b=%b",
                   cyc - 1, slice_a, slice_b, a[cyc-1], b[cyc-1]);
        end
      end
      if (cyc == 1) begin
        n_checks++;
        if (slice_cin !== 1'b1) begin
          n_errors++;
          $display("FAIL slice_cin_bit0: got %b required 1", slice_cin);
        end
      end
      if (done === 1'b1) begin
        got = 1'b1;
        done_cnt++;
        n_checks++;
        if (cyc != int'(WIDTH) + 1) begin
          n_errors++;
          $display("FAIL latency: done after %0d cycles required %0d", cyc, WIDTH + 1);
        end
        n_checks++;
        if (busy_cnt != int'(WIDTH) || busy !== 1'b0) begin
          n_errors++;
          $display("FAIL busy_cycles: %0d (busy now %b) required %0d (0)", busy_cnt, busy, WIDTH);
        end
        exp_v = exp_q.pop_front();
`ifdef SERIAL_SUB_FLAGS_EN
        got_v = {result, no_borrow, zero, ovf};
`else
        got_v = {result, no_borrow, exp_v[1:0]};
`endif
        n_checks++;
        if (got_v !== exp_v) begin
          n_errors++;
          $display("FAIL result %h-%h: res=%h nb=%b zo=%b required res=%h nb=%b zo=%b",
                   a, b, got_v[WIDTH+2:3], got_v[2], got_v[1:0],
                   exp_v[WIDTH+2:3], exp_v[2], exp_v[1:0]);
        end
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout %h-%h: no done within 40 cycles required done", a, b);
      exp_q.delete();
    end else begin
      // Cycle after done: back in IDLE, any held start was ignored
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== d ||
          {slice_a, slice_b, slice_cin} !== 3'b000) begin
        n_errors++;
        $display("FAIL post_done %h-%h: done=%b busy=%b res=%h slice=%b%b%b required 0 0 %h 000",
                 a, b, done, busy, result, slice_a, slice_b, slice_cin, d);
      end
      start = 1'b0;
    end
  endtask

  task automatic test_mid_reset();
    int dones;
    op_a = 8'h35; op_b = 8'h12; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);  // bits 0..3 processed
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, result, slice_a, slice_b, slice_cin} !== '0) begin
      n_errors++;
      $display("FAIL mid_reset: busy=%b done=%b result=%h slice=%b%b%b required all 0",
               busy, done, result, slice_a, slice_b, slice_cin);
    end
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_errors++;
      $display("FAIL mid_reset_quiet: %0d active cycles after reset required 0", dones);
    end
  endtask

  initial begin
    test_reset();
    // basic vectors
    test_op(8'h35, 8'h12, 1'b0, 1'b0);
    test_op(8'h12, 8'h35, 1'b0, 1'b0);
    test_op(8'h80, 8'h80, 1'b0, 1'b0);
    test_op(8'h80, 8'h01, 1'b0, 1'b0);
    test_op(8'h00, 8'h01, 1'b0, 1'b0);
    test_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    test_op(8'h7F, 8'hFF, 1'b0, 1'b0);
    // start held through RUN and DONE: one done only, then back-to-back accept
    test_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    test_op(8'h3C, 8'hC3, 1'b0, 1'b0);
    // operands scrambled while running
    test_op(8'h35, 8'h12, 1'b0, 1'b1);
    // random
    for (int i = 0; i < 6; i++) begin
      test_op(WIDTH'($urandom), WIDTH'($urandom), 1'b0, 1'b0);
    end
    test_mid_reset();
    // recovers after mid-run reset
    test_op(8'h35, 8'h12, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
